// File: rtl/lfsr_victim_sel_if.sv
// ---------------------------------------------------------------------------
// lfsr_victim_sel_if
// Request/response bundle between a cache tag pipeline (master) and the
// LFSR victim selector (slave). WAYS must match the selector's WAYS.
// ---------------------------------------------------------------------------
interface lfsr_victim_sel_if #(
  parameter int WAYS = 4
);
  localparam int WAY_W = $clog2(WAYS);

  logic             req_valid;
  logic             req_ready;
  logic [WAYS-1:0]  valid_mask;
  logic [WAYS-1:0]  lock_mask;
  logic             resp_valid;
  logic             resp_ready;
  logic [WAY_W-1:0] victim_way;
  logic             resp_none;

  // Requester side: issues lookups, consumes victim results.
  modport master (
    output req_valid, valid_mask, lock_mask, resp_ready,
    input  req_ready, resp_valid, victim_way, resp_none
  );

  // Selector side.
  modport slave (
    input  req_valid, valid_mask, lock_mask, resp_ready,
    output req_ready, resp_valid, victim_way, resp_none
  );
endinterface

// File: rtl/lfsr_victim_sel.sv
// ---------------------------------------------------------------------------
// lfsr_victim_sel
// Cache replacement victim selector. Prefers an invalid unlocked way, else
// draws pseudo-random ways from an 8-bit LFSR (x^8+x^6+x^5+x^4+1, right
// shift, seed 8'h42), retrying on locked ways up to MAX_RETRY draws before
// falling back to the lowest unlocked way.
//
// Optional build macro VSEL_PERF_CNT_EN adds saturating 16-bit counters of
// random-draw and fallback decisions (fallback_cnt, random_cnt).
// ---------------------------------------------------------------------------
module lfsr_victim_sel #(
  parameter  int WAYS      = 4,
  parameter  int MAX_RETRY = 3,
  localparam int WAY_W     = $clog2(WAYS)
) (
  input  logic clk,
  input  logic rst_aL,
  input  logic init,
`ifdef VSEL_PERF_CNT_EN
  output logic [15:0] fallback_cnt,
  output logic [15:0] random_cnt,
`endif
  lfsr_victim_sel_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h42;
  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

  state_e           state_q,  state_d;
  logic [7:0]       lfsr_q,   lfsr_d;
  logic [3:0]       retry_q,  retry_d;
  logic [WAYS-1:0]  valid_q,  valid_d;
  logic [WAYS-1:0]  lock_q,   lock_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic             none_q,   none_d;
`ifdef VSEL_PERF_CNT_EN
  logic [15:0]      fall_cnt_q, fall_cnt_d;
  logic [15:0]      rand_cnt_q, rand_cnt_d;
`endif

  logic [7:0]       lfsr_next;
  logic [WAY_W-1:0] draw;
  logic             free_any;
  logic [WAY_W-1:0] free_idx;
  logic [WAY_W-1:0] unlocked_idx;

  // LFSR step and the draw taken from the pre-advance value.
  assign lfsr_next = {lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3], lfsr_q[7:1]};
  assign draw      = lfsr_q[WAY_W-1:0];

  // Priority encoders: lowest invalid+unlocked way and lowest unlocked way.
  always_comb begin
    free_any     = 1'b0;
    free_idx     = '0;
    unlocked_idx = '0;
    // Scan high to low so the lowest matching index is written last.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[i] && !lock_q[i]) begin
        free_any = 1'b1;
        free_idx = WAY_W'(i);
      end
      if (!lock_q[i]) begin
        unlocked_idx = WAY_W'(i);
      end
    end
  end

  // Next-state and datapath decisions for the IDLE/EVAL/RESP controller.
  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    retry_d  = retry_q;
    valid_d  = valid_q;
    lock_d   = lock_q;
    victim_d = victim_q;
    none_d   = none_q;
`ifdef VSEL_PERF_CNT_EN
    fall_cnt_d = fall_cnt_q;
    rand_cnt_d = rand_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          valid_d = bus.valid_mask;
          lock_d  = bus.lock_mask;
          retry_d = '0;
          state_d = ST_EVAL;
        end
      end

      ST_EVAL: begin
        // One draw is consumed per EVAL cycle regardless of which rule fires.
        lfsr_d = lfsr_next;
        if (&lock_q) begin
          none_d   = 1'b1;
          victim_d = '0;
          state_d  = ST_RESP;
        end else if (free_any) begin
          none_d   = 1'b0;
          victim_d = free_idx;
          state_d  = ST_RESP;
        end else if (!lock_q[draw]) begin
          none_d   = 1'b0;
          victim_d = draw;
          state_d  = ST_RESP;
`ifdef VSEL_PERF_CNT_EN
          if (rand_cnt_q != 16'hFFFF) rand_cnt_d = rand_cnt_q + 16'd1;
`endif
        end else if (retry_q == RETRY_LAST) begin
          none_d   = 1'b0;
          victim_d = unlocked_idx;
          state_d  = ST_RESP;
`ifdef VSEL_PERF_CNT_EN
          if (fall_cnt_q != 16'hFFFF) fall_cnt_d = fall_cnt_q + 16'd1;
`endif
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end

      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Synchronous re-initialise overrides everything with the reset image.
    if (init) begin
      state_d  = ST_IDLE;
      lfsr_d   = LFSR_SEED;
      retry_d  = '0;
      valid_d  = '0;
      lock_d   = '0;
      victim_d = '0;
      none_d   = 1'b0;
`ifdef VSEL_PERF_CNT_EN
      fall_cnt_d = '0;
      rand_cnt_d = '0;
`endif
    end
  end

  // State and datapath registers with asynchronous reset to the seed image.
  always_ff @(posedge clk or negedge rst_aL) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values and simulation order cannot change the result.
    if (!rst_aL) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      retry_q  <= '0;
      valid_q  <= '0;
      lock_q   <= '0;
      victim_q <= '0;
      none_q   <= 1'b0;
`ifdef VSEL_PERF_CNT_EN
      fall_cnt_q <= '0;
      rand_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      retry_q  <= retry_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
      victim_q <= victim_d;
      none_q   <= none_d;
`ifdef VSEL_PERF_CNT_EN
      fall_cnt_q <= fall_cnt_d;
      rand_cnt_q <= rand_cnt_d;
`endif
    end
  end

  // Outputs are direct decodes of registered state.
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.victim_way = victim_q;
  assign bus.resp_none  = none_q;
`ifdef VSEL_PERF_CNT_EN
  assign fallback_cnt = fall_cnt_q;
  assign random_cnt   = rand_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_victim_sel.sv
// ---------------------------------------------------------------------------
// tb_lfsr_victim_sel
// Directed bench for lfsr_victim_sel (WAYS=4, MAX_RETRY=3). Expected results
// are queued when a request is driven and compared when the response shows.
// Build with VSEL_PERF_CNT_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_lfsr_victim_sel;

  localparam int WAYS      = 4;
  localparam int MAX_RETRY = 3;
  localparam int WAY_W     = $clog2(WAYS);
  localparam int BUDGET    = 20;

  typedef struct {
    logic [WAY_W-1:0] way;
    logic             none;
    int               lat;
  } exp_t;

  logic clk;
  logic rst_aL;
  logic init;
`ifdef VSEL_PERF_CNT_EN
  logic [15:0] fallback_cnt;
  logic [15:0] random_cnt;
`endif

  lfsr_victim_sel_if #(.WAYS(WAYS)) bus ();

  lfsr_victim_sel #(
    .WAYS      (WAYS),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk          (clk),
    .rst_aL       (rst_aL),
    .init         (init),
`ifdef VSEL_PERF_CNT_EN
    .fallback_cnt (fallback_cnt),
    .random_cnt   (random_cnt),
`endif
    .bus          (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_aL = 1'b0;
    repeat (2) @(negedge clk);
    rst_aL = 1'b1;
    @(negedge clk);
  endtask

  // Drive one request, push its expectation, scramble masks after accept.
  task automatic send_req(input logic [WAYS-1:0] vm, input logic [WAYS-1:0] lm,
                          input logic [WAY_W-1:0] way, input logic none, input int lat);
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.valid_mask = vm;
    bus.lock_mask  = lm;
    e.way = way; e.none = none; e.lat = lat;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.valid_mask = '0;
    bus.lock_mask  = ~lm;
  endtask

  // Wait for the response, compare against the queue head, optionally stall.
  task automatic wait_resp(input string tag, input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    while (!bus.resp_valid && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    check({tag, "_resp_valid"}, bus.resp_valid, 1);
    check({tag, "_latency"},    lat,            e.lat);
    check({tag, "_victim"},     bus.victim_way, e.way);
    check({tag, "_none"},       bus.resp_none,  e.none);
    check({tag, "_req_ready"},  bus.req_ready,  0);
    for (int i = 0; i < hold; i++) begin
      // A request presented while busy must be ignored.
      bus.req_valid  = 1'b1;
      bus.valid_mask = '0;
      bus.lock_mask  = '0;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"},  bus.resp_valid, 1);
      check({tag, "_hold_ready"},  bus.req_ready,  0);
      check({tag, "_hold_victim"}, bus.victim_way, e.way);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({tag, "_done_valid"},  bus.resp_valid, 0);
    check({tag, "_done_ready"},  bus.req_ready,  1);
    check({tag, "_held_victim"}, bus.victim_way, e.way);
  endtask

  initial begin
    rst_aL         = 1'b0;
    init           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.valid_mask = '0;
    bus.lock_mask  = '0;
    bus.resp_ready = 1'b0;
    #1;
    check("reset_req_ready",  bus.req_ready,  1);
    check("reset_resp_valid", bus.resp_valid, 0);
    check("reset_victim",     bus.victim_way, 0);
    check("reset_none",       bus.resp_none,  0);
    apply_reset();

    // All valid, nothing locked: draws 0x42 -> 2, then 0x21 -> 1.
    send_req(4'hF, 4'h0, 2'd2, 1'b0, 1);
    wait_resp("rand0", 0);
    send_req(4'hF, 4'h0, 2'd1, 1'b0, 1);
    wait_resp("rand1", 0);
`ifdef VSEL_PERF_CNT_EN
    check("perf_random_2", random_cnt,   2);
    check("perf_fall_0",   fallback_cnt, 0);
`endif

    // Invalid way 3 wins; its EVAL cycle still consumes draw 0x42.
    apply_reset();
    send_req(4'b0111, 4'h0, 2'd3, 1'b0, 1);
    wait_resp("invalid", 0);
    send_req(4'hF, 4'h0, 2'd1, 1'b0, 1);
    wait_resp("after_invalid", 0);

    // Draw 2 locked, retry, draw 1 accepted.
    apply_reset();
    send_req(4'hF, 4'b0100, 2'd1, 1'b0, 2);
    wait_resp("retry", 0);

    // Draws 2,1,0 locked -> fallback to lowest unlocked way 3.
    apply_reset();
    send_req(4'hF, 4'b0111, 2'd3, 1'b0, 3);
    wait_resp("fallback", 0);
`ifdef VSEL_PERF_CNT_EN
    check("perf_fall_1",   fallback_cnt, 1);
    check("perf_random_0", random_cnt,   0);
`endif

    // Everything locked: resp_none, stalled consumer for 5 cycles.
    send_req(4'hF, 4'hF, 2'd0, 1'b1, 1);
    wait_resp("all_locked", 5);
    check("none_holds_idle", bus.resp_none, 1);

    // Synchronous init clears outputs and reseeds the LFSR.
    send_req(4'b0111, 4'h0, 2'd3, 1'b0, 1);
    wait_resp("pre_init", 0);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    check("init_victim",    bus.victim_way, 0);
    check("init_none",      bus.resp_none,  0);
    check("init_req_ready", bus.req_ready,  1);
    send_req(4'hF, 4'h0, 2'd2, 1'b0, 1);
    wait_resp("post_init", 0);

    // Reset while in EVAL drops the request.
    apply_reset();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.valid_mask = 4'hF;
    bus.lock_mask  = 4'b0111;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("eval_busy", bus.req_ready, 0);
    rst_aL = 1'b0;
    #1;
    check("rst_eval_resp_valid", bus.resp_valid, 0);
    check("rst_eval_req_ready",  bus.req_ready,  1);
    @(negedge clk);
    rst_aL = 1'b1;
    send_req(4'hF, 4'h0, 2'd2, 1'b0, 1);
    wait_resp("after_rst_eval", 0);

    // Reset while a response is pending drops resp_valid immediately.
    send_req(4'hF, 4'h0, 2'd1, 1'b0, 1);
    @(posedge clk);
    #1;
    void'(sb_q.pop_front());
    check("pre_rst_resp_valid", bus.resp_valid, 1);
    rst_aL = 1'b0;
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_req_ready",  bus.req_ready,  1);
    @(negedge clk);
    rst_aL = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_victim_sel.md
Name: lfsr_victim_sel

Overview:
- Cache replacement controller for the set-associative L1 caches.
- Accepts one victim request per set lookup and returns the way to evict.
- Prefers invalid, unlocked ways. Otherwise it draws pseudo-random ways from an internal 8-bit LFSR, retrying on locked ways, with a bounded deterministic fallback.
- Sits beside the cache tag array; owns and sequences its own LFSR instance.

Parameters:
- WAYS, 4, number of ways; power of two, 2..256.
- WAY_W, $clog2(WAYS), victim index width; derived, do not override.
- MAX_RETRY, 3, maximum LFSR draws per request before fallback; 1..15.

Ports:
- clk  input  1  clock.
- rst_aL  input  1  asynchronous active-low reset.
- init  input  1  synchronous re-initialise: same effect as reset, at the clock edge.
- req_valid  input  1  victim request.
- req_ready  output  1  high only in IDLE.
- valid_mask  input  WAYS  per-way valid bits; sampled on accept.
- lock_mask  input  WAYS  per-way locked (non-evictable) bits; sampled on accept.
- resp_valid  output  1  victim result valid.
- resp_ready  input  1  consumer accepts result.
- victim_way  output  WAY_W  selected way.
- resp_none  output  1  all ways locked; victim_way is 0 and must be ignored.

Behaviour:
- Reset / init:
  - FSM goes to IDLE; LFSR = 8'h42; retry_cnt = 0.
  - Outputs: resp_valid=0, victim_way=0, resp_none=0, req_ready=1.
  - Reset mid-request drops the request with no response.
- LFSR:
  - Polynomial x^8+x^6+x^5+x^4+1; shifts right; feedback = r[7]^r[5]^r[4]^r[3] into the MSB.
  - Advances only on clock edges where the FSM is in EVAL, one draw per EVAL cycle, whatever the outcome.
  - Draw = r[WAY_W-1:0] (the value before the advance). Sequence from seed: 42,21,90,48,A4.
- FSM IDLE:
  - req_ready=1.
  - On req_valid: latch valid_mask and lock_mask, clear retry_cnt, go to EVAL.
- FSM EVAL (one decision per cycle), first matching rule wins:
  - (a) All ways locked: resp_none=1, victim=0, go to RESP.
  - (b) Any way with valid=0 and lock=0: victim = lowest such index, go to RESP.
  - (c) Draw not locked: victim = draw, go to RESP.
  - (d) Draw locked and retry_cnt == MAX_RETRY-1: victim = lowest unlocked index, go to RESP.
  - (e) Otherwise: retry_cnt++, stay in EVAL.
- FSM RESP:
  - resp_valid=1; victim_way and resp_none are registered and stable.
  - On resp_ready go to IDLE. A new request can be accepted no earlier than the following cycle.
- Latency:
  - Request accepted at edge N gives resp_valid=1 after edge N+1+k, where k = number of rule-(e) cycles (k ≤ MAX_RETRY-1).
- Outputs:
  - All outputs are registered.
  - victim_way and resp_none hold their last value outside RESP.
  - req_valid is ignored outside IDLE.
  - valid_mask and lock_mask changes after accept have no effect.

Optional Feature:
- Macro VSEL_PERF_CNT_EN.
- Defined:
  - Adds output fallback_cnt [15:0]: saturating count of rule-(d) decisions.
  - Adds output random_cnt [15:0]: saturating count of rule-(c) decisions.
  - Both counters clear on reset or init.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, WAYS=4, valid_mask=4'hF, lock_mask=0, request accepted at edge N -> resp_valid after N+1; victim_way=2, resp_none=0. Second request -> victim_way=1.
- Fresh reset, valid_mask=4'b0111, lock_mask=0 -> victim_way=3 via rule (b), latency 1. A following all-valid request -> victim_way=1, because draw 0x42 was consumed.
- Fresh reset, valid_mask=4'hF, lock_mask=4'b0100 -> draw 2 locked, retry, draw 1 -> victim_way=1; resp_valid after N+2.
- Fresh reset, valid_mask=4'hF, lock_mask=4'b0111, MAX_RETRY=3 -> draws 2,1,0 all locked -> fallback victim_way=3 after N+3. With VSEL_PERF_CNT_EN, fallback_cnt=1.
- lock_mask=4'hF -> resp_none=1, victim_way=0, latency 1. Hold resp_ready=0 for 5 cycles -> resp_valid stays 1, req_ready stays 0.
- Assert rst_aL low while in EVAL -> resp_valid=0 immediately. After release: req_ready=1 and the LFSR restarts at 0x42, so the first draw is 2.
